controlador_alarme: RTL and testbench
=====================================

Name: controlador_alarme

Overview:
- Moore state machine that sequences the residential security system: arming, exit delay, armed watch, entry delay, and alarm.
- Owns the 3-minute delay timer. It drives the timer's three clear lines and watches its expiry flag `hab`.
- Sits between the keypad/code-check logic, the zone sensors, and the siren/LED outputs.

Parameters:
- N_ZONES, 4, number of sensor zone inputs.
- MAX_TRIES, 3, consecutive wrong disarm codes that force ALARM; range 1..7.

Ports:
- clk  in  1  system clock.
- clr  in  1  asynchronous active-low reset.
- arm_req  in  1  one-cycle arm request from the keypad.
- disarm_req  in  1  one-cycle disarm request; qualified by code_ok in the same cycle.
- code_ok  in  1  entered code matches; sampled only when disarm_req=1.
- sensor  in  N_ZONES  zone open flags; 1 means open/tripped.
- timer_hab  in  1  expiry flag from the 3-minute timer.
- timer_clr  out  3  clear lines to the timer (hour/min/sec digit counters); 3'b111 holds it cleared, 3'b000 lets it run.
- siren  out  1  alarm output.
- armed  out  1  system armed (ARMED or ENTRY_DELAY).
- delay_active  out  1  EXIT_DELAY or ENTRY_DELAY.
- zone  out  N_ZONES  latched zone(s) that caused entry.
- fault  out  1  one-cycle pulse when an arm request is refused.
- state  out  3  current state code, for the display.

Behaviour:
- States: DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3, ALARM=4, PANIC=5 (PANIC only when the optional feature is compiled in).
- Reset (clr=0, asynchronous):
  - state=DISARMED, timer_clr=3'b111, siren=0, armed=0, delay_active=0, zone=0, fault=0.
  - tries=0, hab_q=0.
- Expiry is a registered rising-edge detect: `expiry = timer_hab & ~hab_q`, where hab_q is timer_hab delayed one clk.
- Outputs are registered from next_state, so they change on the same edge as state.
- timer_clr:
  - 3'b000 in EXIT_DELAY and ENTRY_DELAY.
  - 3'b111 in all other states, so the timer restarts from zero on every delay entry.
- DISARMED:
  - arm_req with sensor==0 → EXIT_DELAY.
  - arm_req with any sensor bit set → stay in DISARMED and pulse fault for 1 cycle.
  - tries is held at 0.
- EXIT_DELAY:
  - disarm_req & code_ok → DISARMED.
  - Otherwise expiry → ARMED.
  - Sensors are ignored.
- ARMED:
  - Any sensor bit → ENTRY_DELAY, and zone <= sensor, captured on the transition edge.
  - disarm_req & code_ok → DISARMED.
- ENTRY_DELAY:
  - disarm_req & code_ok → DISARMED.
  - Otherwise expiry → ALARM.
  - zone holds its value; additional open zones are OR-ed into zone.
- ALARM:
  - siren=1.
  - Stays until disarm_req & code_ok → DISARMED.
  - Sensor and expiry are ignored.
- Wrong code (disarm_req & ~code_ok) in any state other than DISARMED:
  - tries increments, saturating at MAX_TRIES.
  - When tries reaches MAX_TRIES, the FSM goes to ALARM on that same edge.
- Correct disarm:
  - Clears tries and zone; siren=0 next cycle.
- Simultaneous events (priority, highest first): correct disarm > wrong-code lockout > expiry > sensor > arm_req.
- arm_req outside DISARMED is ignored.
- An expiry pulse arriving outside a delay state is ignored.
- Reset mid-delay aborts immediately and returns to DISARMED with the timer held cleared.

Optional Feature:
- Macro: PANIC_INPUT_EN.
- When defined:
  - Adds input port `panic` (1 bit).
  - panic=1 in any state → PANIC on the next edge.
  - PANIC: siren=1, armed=0, timer_clr=3'b111. It exits only via disarm_req & code_ok → DISARMED.
  - panic outranks everything except reset.
- When undefined:
  - No port and no PANIC state.
  - State code 5 is unreachable, and any illegal state recovers to DISARMED.

Decomposition:
- Shared package: state encodings (ST_DISARMED..ST_PANIC), TIMER_HOLD=3'b111, TIMER_RUN=3'b000, STATE_W=3.
- One sub-module, `detector_borda`, does the rising-edge detection of timer_hab. It is a registered edge detector with async active-low clr.
- The FSM, tries counter and zone latch stay in the top module.

Test Plan:
- Reset, then arm_req with sensor=4'b0000 → state=1, timer_clr=000, delay_active=1; force a timer_hab rise → state=2, armed=1, timer_clr=111.
- In DISARMED, sensor=4'b0010 with arm_req → state stays 0 and fault=1 for exactly one cycle.
- From ARMED, sensor=4'b0100 → state=3, zone=0100; timer_hab rise → state=4, siren=1; disarm_req+code_ok → state=0, siren=0, zone=0.
- From ARMED, three disarm_req with code_ok=0 (MAX_TRIES=3) → state=4 on the third request's edge; then a correct code → state=0 and tries=0.
- In ENTRY_DELAY, assert a timer_hab rise and disarm_req+code_ok in the same cycle → state=0, no siren.
- PANIC_INPUT_EN defined: in ARMED assert panic=1 → state=5, siren=1, armed=0; correct disarm → state=0.

Source files
------------

// File: rtl/controlador_alarme_pkg.sv
// Shared encodings for the alarm controller: state codes, timer clear patterns.
// The PANIC_INPUT_EN build reuses ST_PANIC; other builds leave code 5 unreachable.
package controlador_alarme_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_DISARMED    = 3'd0;
  localparam logic [STATE_W-1:0] ST_EXIT_DELAY  = 3'd1;
  localparam logic [STATE_W-1:0] ST_ARMED       = 3'd2;
  localparam logic [STATE_W-1:0] ST_ENTRY_DELAY = 3'd3;
  localparam logic [STATE_W-1:0] ST_ALARM       = 3'd4;
  localparam logic [STATE_W-1:0] ST_PANIC       = 3'd5;

  localparam logic [2:0] TIMER_HOLD = 3'b111;
  localparam logic [2:0] TIMER_RUN  = 3'b000;

  function automatic logic is_delay(input logic [STATE_W-1:0] s);
    return (s == ST_EXIT_DELAY) || (s == ST_ENTRY_DELAY);
  endfunction

endpackage

// File: rtl/controlador_alarme_detector_borda.sv
// Registered rising-edge detector for the delay timer's expiry flag.
// rise is combinational from din and the registered copy of din.
module detector_borda (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) din_q <= 1'b0;
    else      din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/controlador_alarme.sv
// Residential alarm sequencer: exit delay, armed watch, entry delay, alarm.
// Define PANIC_INPUT_EN to add the panic input and PANIC state.
module controlador_alarme
  import controlador_alarme_pkg::*;
#(
  parameter int N_ZONES   = 4,
  parameter int MAX_TRIES = 3
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               arm_req,
  input  logic               disarm_req,
  input  logic               code_ok,
  input  logic [N_ZONES-1:0] sensor,
  input  logic               timer_hab,
`ifdef PANIC_INPUT_EN
  input  logic               panic,
`endif
  output logic [2:0]         timer_clr,
  output logic               siren,
  output logic               armed,
  output logic               delay_active,
  output logic [N_ZONES-1:0] zone,
  output logic               fault,
  output logic [STATE_W-1:0] state
);

  localparam logic [2:0] MAX_T = 3'(MAX_TRIES);

  logic               expiry;
  logic [STATE_W-1:0] next_state;
  logic [2:0]         tries_q, next_tries, tries_sat;
  logic [N_ZONES-1:0] next_zone;
  logic               next_fault;
  logic               good_code, bad_code;

  detector_borda u_borda (
    .clk  (clk),
    .clr  (clr),
    .din  (timer_hab),
    .rise (expiry)
  );

  // Keypad requests are single-cycle pulses with no backpressure; code_ok
  // only has meaning in a cycle where disarm_req is high.
  assign good_code = disarm_req & code_ok;
  assign bad_code  = disarm_req & ~code_ok;
  assign tries_sat = (tries_q >= MAX_T) ? MAX_T : tries_q + 3'd1;

  always_comb begin
    next_state = state;
    next_tries = tries_q;
    next_zone  = zone;
    next_fault = 1'b0;
    case (state)
      ST_DISARMED: begin
        next_tries = '0;
        if (arm_req) begin
          if (sensor == '0) next_state = ST_EXIT_DELAY;
          else              next_fault = 1'b1;
        end
      end
      ST_EXIT_DELAY, ST_ARMED, ST_ENTRY_DELAY, ST_ALARM: begin
        if (good_code) begin
          next_state = ST_DISARMED;
          next_tries = '0;
          next_zone  = '0;
        end else begin
          if (state == ST_ENTRY_DELAY) next_zone = zone | sensor;
          if (bad_code) next_tries = tries_sat;
          // Lockout outranks expiry and sensors; a non-final wrong code does not.
          if (bad_code && (tries_sat == MAX_T))
            next_state = ST_ALARM;
          else if ((state == ST_EXIT_DELAY) && expiry)
            next_state = ST_ARMED;
          else if ((state == ST_ENTRY_DELAY) && expiry)
            next_state = ST_ALARM;
          else if ((state == ST_ARMED) && (|sensor)) begin
            next_state = ST_ENTRY_DELAY;
            next_zone  = sensor;
          end
        end
      end
`ifdef PANIC_INPUT_EN
      ST_PANIC: begin
        if (good_code) begin
          next_state = ST_DISARMED;
          next_tries = '0;
          next_zone  = '0;
        end else if (bad_code) begin
          next_tries = tries_sat;
        end
      end
`endif
      default: begin
        next_state = ST_DISARMED;
        next_tries = '0;
        next_zone  = '0;
      end
    endcase
`ifdef PANIC_INPUT_EN
    if (panic) begin
      next_state = ST_PANIC;
      next_fault = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state        <= ST_DISARMED;
      tries_q      <= '0;
      zone         <= '0;
      fault        <= 1'b0;
      timer_clr    <= TIMER_HOLD;
      siren        <= 1'b0;
      armed        <= 1'b0;
      delay_active <= 1'b0;
    end else begin
      state        <= next_state;
      tries_q      <= next_tries;
      zone         <= next_zone;
      fault        <= next_fault;
      timer_clr    <= is_delay(next_state) ? TIMER_RUN : TIMER_HOLD;
      siren        <= (next_state == ST_ALARM) || (next_state == ST_PANIC);
      armed        <= (next_state == ST_ARMED) || (next_state == ST_ENTRY_DELAY);
      delay_active <= is_delay(next_state);
    end
  end

endmodule

// File: tb/tb_controlador_alarme.sv
// Bench for controlador_alarme: directed scenarios then random stimulus,
// all outputs compared each cycle against a behavioural model.
module tb_controlador_alarme;

  localparam int MAX_TRIES = 3;
  localparam int W = 14;

  logic       clk = 1'b0;
  logic       clr;
  logic       arm_req, disarm_req, code_ok, timer_hab, panic;
  logic [3:0] sensor;
  logic [2:0] timer_clr;
  logic       siren, armed, delay_active, fault;
  logic [3:0] zone;
  logic [2:0] state;

  controlador_alarme #(.N_ZONES(4), .MAX_TRIES(MAX_TRIES)) dut (
    .clk          (clk),
    .clr          (clr),
    .arm_req      (arm_req),
    .disarm_req   (disarm_req),
    .code_ok      (code_ok),
    .sensor       (sensor),
    .timer_hab    (timer_hab),
`ifdef PANIC_INPUT_EN
    .panic        (panic),
`endif
    .timer_clr    (timer_clr),
    .siren        (siren),
    .armed        (armed),
    .delay_active (delay_active),
    .zone         (zone),
    .fault        (fault),
    .state        (state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // Model: mode is the display code of the system's situation.
  int         m_mode;
  int         m_tries;
  logic [3:0] m_zone;
  logic       m_hab_prev;
  logic       m_fault;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_tries = 0; m_zone = '0; m_hab_prev = 1'b0; m_fault = 1'b0;
  endtask

  task automatic model_step();
    logic rose, good, wrong;
    rose  = timer_hab && !m_hab_prev;
    good  = disarm_req && code_ok;
    wrong = disarm_req && !code_ok;
    m_fault = 1'b0;
    if (panic) begin
      m_mode = 5;
    end else if (m_mode == 0) begin
      m_tries = 0;
      if (arm_req && sensor == 0) m_mode = 1;
      else if (arm_req) m_fault = 1'b1;
    end else if (good) begin
      m_mode = 0; m_tries = 0; m_zone = '0;
    end else if (m_mode == 5) begin
      if (wrong && m_tries < MAX_TRIES) m_tries++;
    end else begin
      if (m_mode == 3) m_zone = m_zone | sensor;
      if (wrong && m_tries < MAX_TRIES) m_tries++;
      if (wrong && m_tries == MAX_TRIES) m_mode = 4;
      else if (m_mode == 1 && rose) m_mode = 2;
      else if (m_mode == 3 && rose) m_mode = 4;
      else if (m_mode == 2 && sensor != 0) begin
        m_zone = sensor; m_mode = 3;
      end
    end
    m_hab_prev = timer_hab;
  endtask

  function automatic logic [W-1:0] model_pack();
    logic in_delay;
    in_delay = (m_mode == 1) || (m_mode == 3);
    return {3'(m_mode), in_delay ? 3'b000 : 3'b111, (m_mode == 4) || (m_mode == 5),
            (m_mode == 2) || (m_mode == 3), in_delay, m_fault, m_zone};
  endfunction

  task automatic cycle();
    logic [W-1:0] e;
    model_step();
    exp_q.push_back(model_pack());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("state",        state,        e[13:11]);
    check("timer_clr",    timer_clr,    e[10:8]);
    check("siren",        siren,        e[7]);
    check("armed",        armed,        e[6]);
    check("delay_active", delay_active, e[5]);
    check("fault",        fault,        e[4]);
    check("zone",         zone,         e[3:0]);
  endtask

  task automatic drive(input logic a, input logic d, input logic c,
                       input logic [3:0] s, input logic h);
    arm_req = a; disarm_req = d; code_ok = c; sensor = s; timer_hab = h;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 4'b0000, 0);
  endtask

  task automatic arm_to_armed();
    drive(1, 0, 0, 4'b0000, 0);
    idle(2);
    drive(0, 0, 0, 4'b0000, 1);
    drive(0, 0, 0, 4'b0000, 0);
  endtask

  initial begin
    clr = 1'b0; arm_req = 0; disarm_req = 0; code_ok = 0; panic = 0;
    sensor = '0; timer_hab = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_state",     state,        3'd0);
    check("rst_timer_clr", timer_clr,    3'b111);
    check("rst_siren",     siren,        1'b0);
    check("rst_armed",     armed,        1'b0);
    check("rst_delay",     delay_active, 1'b0);
    check("rst_zone",      zone,         4'b0000);
    check("rst_fault",     fault,        1'b0);
    clr = 1'b1;

    // Arm, exit delay, expiry into ARMED.
    arm_to_armed();
    check("armed_state", state, 3'd2);
    // Three wrong codes lock out on the third.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 4'b0000, 0);
      idle(1);
    end
    check("lockout_state", state, 3'd4);
    drive(0, 1, 1, 4'b0000, 0);
    // Refused arm with an open zone.
    drive(1, 0, 0, 4'b0010, 0);
    check("fault_pulse", fault, 1'b1);
    idle(1);
    check("fault_clear", fault, 1'b0);
    // Tries were cleared: two wrong codes must not alarm.
    arm_to_armed();
    drive(0, 1, 0, 4'b0000, 0);
    drive(0, 1, 0, 4'b0000, 0);
    check("tries_cleared", state, 3'd2);
    drive(0, 1, 1, 4'b0000, 0);
    // Entry delay, zone OR-ing, expiry to ALARM, disarm.
    arm_to_armed();
    drive(0, 0, 0, 4'b0100, 0);
    check("entry_zone", zone, 4'b0100);
    drive(0, 0, 0, 4'b1000, 0);
    drive(0, 0, 0, 4'b0000, 1);
    check("alarm_siren", siren, 1'b1);
    drive(0, 1, 1, 4'b0000, 0);
    // Expiry and correct disarm together: disarm wins.
    arm_to_armed();
    drive(0, 0, 0, 4'b0001, 0);
    drive(0, 1, 1, 4'b0000, 1);
    check("tie_state", state, 3'd0);
    idle(1);
    // Asynchronous reset in the middle of exit delay.
    drive(1, 0, 0, 4'b0000, 0);
    clr = 1'b0;
    #1;
    check("midrst_state",     state,     3'd0);
    check("midrst_timer_clr", timer_clr, 3'b111);
    check("midrst_delay",     delay_active, 1'b0);
    model_reset();
    #2 clr = 1'b1;
    idle(2);
`ifdef PANIC_INPUT_EN
    arm_to_armed();
    panic = 1'b1;
    drive(0, 0, 0, 4'b0000, 0);
    panic = 1'b0;
    check("panic_state", state, 3'd5);
    drive(0, 1, 1, 4'b0000, 0);
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 8,
            $urandom_range(0, 1) == 1,
            ($urandom_range(0, 99) < 15) ? 4'($urandom_range(1, 15)) : 4'b0000,
            $urandom_range(0, 99) < 12);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
